// File: rtl/bf_pkg.sv
// Shared Bellman-Ford definitions: graph size, index widths and the controller
// state encoding that both the controller and the AGU decode.
package bf_pkg;

   localparam int BF_N_NODES = 16;
   localparam int BF_IDX_W   = 4;
   localparam int BF_CNT_W   = 5;

   typedef enum logic [1:0] {
      CTRL_IDLE = 2'b00,
      CTRL_INIT = 2'b01,
      CTRL_WAIT = 2'b10,
      CTRL_PROC = 2'b11
   } ctrl_state_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_SWEEP,
      S_DONE
   } agu_state_e;

endpackage

// File: rtl/bf_idx_counter.sv
// Row/col wrap counter over a square matrix; col is the fast index.
// o_last flags the {max,max} edge so the caller can close the sweep.
module bf_idx_counter #(
   parameter int IDX_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [IDX_W-1:0] o_row,
   output logic [IDX_W-1:0] o_col,
   output logic             o_last
);

   logic [IDX_W-1:0] r_row;
   logic [IDX_W-1:0] r_col;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_en) begin
         r_col <= r_col + IDX_W'(1);
         if (&r_col) r_row <= r_row + IDX_W'(1);
      end
   end

   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_last = (&r_row) & (&r_col);

endmodule

// File: rtl/bf_agu.sv
// Bellman-Ford address-generation unit: walks every {row,col} edge once per sweep,
// counts committed sweeps and flags convergence to the controller.
module bf_agu
   import bf_pkg::*;
#(
   parameter int N_NODES = BF_N_NODES,
   parameter int IDX_W   = BF_IDX_W,
   parameter int CNT_W   = BF_CNT_W
) (
   input  logic               i_clk,
   input  logic               i_rst_global_n,
   input  logic [1:0]         i_ctrl_state,
   input  logic               i_read_enable,
   input  logic               i_write_enable,
   input  logic               i_relax_update,
   output logic [2*IDX_W-1:0] o_edge_addr,
   output logic               o_addr_valid,
   output logic               o_iteration_done,
   output logic               o_finish,
   output logic [CNT_W-1:0]   o_iter_count
);

   agu_state_e       r_state;
   agu_state_e       w_nxt;
   ctrl_state_e      w_ctrl;
   logic             w_start;
   logic             w_commit;
   logic             w_last;
   logic             w_cnt_clr;
   logic             w_cnt_en;
   logic             w_unused_rd;
   logic [IDX_W-1:0] w_row;
   logic [IDX_W-1:0] w_col;
   logic             r_dirty;
   logic             r_finish;
   logic             r_addr_valid;
   logic             r_iter_done;
   logic [CNT_W-1:0] r_iter;

   assign w_ctrl      = ctrl_state_e'(i_ctrl_state);
   assign w_unused_rd = i_read_enable;

   always_ff @(posedge i_clk or negedge i_rst_global_n) begin
      if (!i_rst_global_n) r_state <= S_IDLE;
      else                 r_state <= w_nxt;
   end

   // INIT restarts from anywhere; IDLE aborts any active phase
   always_comb begin
      w_nxt    = r_state;
      w_start  = 1'b0;
      w_commit = 1'b0;
      if (w_ctrl == CTRL_INIT) begin
         w_nxt   = S_ARM;
         w_start = 1'b1;
      end else if (w_ctrl == CTRL_IDLE) begin
         w_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_nxt = S_IDLE;
            S_ARM:   if (w_ctrl == CTRL_PROC && !r_finish) w_nxt = S_SWEEP;
            S_SWEEP: if (w_last) w_nxt = S_DONE;
            S_DONE:  if (i_write_enable) begin
                        w_nxt    = S_ARM;
                        w_commit = 1'b1;
                     end
            default: w_nxt = S_IDLE;
         endcase
      end
   end

   assign w_cnt_en  = (r_state == S_SWEEP);
   assign w_cnt_clr = (w_nxt != S_SWEEP);

   bf_idx_counter #(.IDX_W(IDX_W)) u_idx (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_global_n),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .o_row   (w_row),
      .o_col   (w_col),
      .o_last  (w_last)
   );

   // The commit cycle's own relax_update still counts toward this sweep
   always_ff @(posedge i_clk or negedge i_rst_global_n) begin
      if (!i_rst_global_n) begin
         r_addr_valid <= 1'b0;
         r_iter_done  <= 1'b0;
         r_dirty      <= 1'b0;
         r_finish     <= 1'b0;
         r_iter       <= '0;
      end else begin
         r_addr_valid <= (w_nxt == S_SWEEP);
         r_iter_done  <= (w_nxt == S_DONE);
         if (w_start) begin
            r_iter   <= '0;
            r_finish <= 1'b0;
            r_dirty  <= 1'b0;
         end else if (w_commit) begin
            if (r_iter != CNT_W'(N_NODES-1)) r_iter <= r_iter + CNT_W'(1);
            r_finish <= (r_iter + CNT_W'(1) == CNT_W'(N_NODES-1)) | ~(r_dirty | i_relax_update);
            r_dirty  <= 1'b0;
         end else if ((r_state == S_SWEEP || r_state == S_DONE) && i_relax_update) begin
            r_dirty <= 1'b1;
         end
      end
   end

   assign o_edge_addr      = {w_row, w_col};
   assign o_addr_valid     = r_addr_valid;
   assign o_iteration_done = r_iter_done;
   assign o_finish         = r_finish;
   assign o_iter_count     = r_iter;

endmodule
